// File: rtl/output_delta_unit.sv
// rtl/output_delta_unit.sv - output-layer delta computation (a - y) * sp into a ping-pong delta buffer
module output_delta_unit #(
    parameter int n         = 8,
    parameter int z         = 8,
    parameter int fi        = 4,
    parameter int width     = 16,
    parameter int int_bits  = 5,
    parameter int frac_bits = 10,
    localparam int M        = z / fi,
    localparam int C        = n / M,
    localparam int CW       = (C > 1) ? $clog2(C) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [width*M-1:0] sigmoid_package,
    input  logic [width*M-1:0] sp_package,
    input  logic [width*M-1:0] y_package,
    output logic               out_valid,
    input  logic               rd_en,
    input  logic [CW-1:0]      rd_cycle,
    output logic [width*M-1:0] delta_package,
    input  logic               rd_release,
    output logic               sample_done
);

    if ((n % M) != 0 || (int_bits + frac_bits + 1) != width) begin : g_bad_params
        $error("output_delta_unit: inconsistent n/z/fi or fixed-point format");
    end

    function automatic logic [width-1:0] sat_sub(input logic [width-1:0] a, input logic [width-1:0] b);
        logic [width:0] d;
        d = {a[width-1], a} - {b[width-1], b};
        if (d[width] != d[width-1])
            sat_sub = d[width] ? {1'b1, {(width-1){1'b0}}} : {1'b0, {(width-1){1'b1}}};
        else
            sat_sub = d[width-1:0];
    endfunction

    // Floor-shifted product; the upper bits must be pure sign extension to fit in width bits.
    function automatic logic [width-1:0] mul_shift(input logic [width-1:0] d, input logic [width-1:0] sp);
        logic signed [2*width-1:0] p;
        logic signed [2*width-1:0] s;
        p = $signed({{width{d[width-1]}}, d}) * $signed({{width{sp[width-1]}}, sp});
        s = p >>> frac_bits;
        if ((&s[2*width-1:width-1]) || !(|s[2*width-1:width-1]))
            mul_shift = s[width-1:0];
        else
            mul_shift = s[2*width-1] ? {1'b1, {(width-1){1'b0}}} : {1'b0, {(width-1){1'b1}}};
    endfunction

    logic [1:0]         full_cnt;
    logic [1:0]         pend_cnt;
    logic [CW-1:0]      wr_cycle;
    logic [CW-1:0]      s1_addr;
    logic               wr_bank;
    logic               rd_bank;
    logic               s1_valid;
    logic               s1_last;
    logic [width*M-1:0] s1_diff;
    logic [width*M-1:0] s1_sp;
    logic [width*M-1:0] diff_next;
    logic [width*M-1:0] wr_data;
    logic [width*M-1:0] mem [0:(2**(CW+1))-1];

    logic accept;
    logic last_accept;
    logic release_ok;
    logic commit;

    assign in_ready    = (pend_cnt < 2'd2);
    assign out_valid   = (full_cnt != 2'd0);
    assign accept      = in_valid && in_ready;
    assign last_accept = accept && (wr_cycle == CW'(C - 1));
    assign release_ok  = rd_release && out_valid;
    assign commit      = s1_valid && s1_last;

    always_comb begin
        diff_next = '0;
        wr_data   = '0;
        for (int k = 0; k < M; k++) begin
            diff_next[k*width +: width] = sat_sub(sigmoid_package[k*width +: width], y_package[k*width +: width]);
            wr_data[k*width +: width]   = mul_shift(s1_diff[k*width +: width], s1_sp[k*width +: width]);
        end
    end

    always_ff @(posedge clk) begin
        if (s1_valid)
            mem[{wr_bank, s1_addr}] <= wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid      <= 1'b0;
            s1_last       <= 1'b0;
            s1_addr       <= '0;
            s1_diff       <= '0;
            s1_sp         <= '0;
            wr_cycle      <= '0;
            wr_bank       <= 1'b0;
            rd_bank       <= 1'b0;
            full_cnt      <= 2'd0;
            pend_cnt      <= 2'd0;
            sample_done   <= 1'b0;
            delta_package <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_addr  <= wr_cycle;
                s1_last  <= last_accept;
                s1_diff  <= diff_next;
                s1_sp    <= sp_package;
                wr_cycle <= last_accept ? '0 : wr_cycle + CW'(1);
            end
            sample_done <= commit;
            if (commit)
                wr_bank <= ~wr_bank;
            if (release_ok)
                rd_bank <= ~rd_bank;
            // A sample is counted in pend_cnt at acceptance of its last beat, so commit only moves full_cnt.
            full_cnt <= full_cnt + {1'b0, commit} - {1'b0, release_ok};
            pend_cnt <= pend_cnt + {1'b0, last_accept} - {1'b0, release_ok};
            if (rd_en && out_valid)
                delta_package <= mem[{rd_bank, rd_cycle}];
        end
    end

endmodule

// File: doc/output_delta_unit.md
Name: output_delta_unit

Overview:
- Sits directly downstream of the output-layer feedforward processor set and upstream of the backprop/update processor sets.
- Each cycle it accepts z/fi sigmoid (a) and sigmoid-prime (sp) values plus the matching ideal outputs (y), and computes deln = (a - y) * sp in fixed point.
- Results are stored into a ping-pong delta buffer of n entries. BP/UP read deltas z/fi at a time while the next sample fills the other bank.

Parameters:
n, 8, number of output-layer neurons; must be a multiple of z/fi
z, 8, junction parallelism
fi, 4, fan-in; M = z/fi neurons per beat, C = n/M beats per sample
width, 16, fixed-point word width (two's complement)
int_bits, 5, integer bits
frac_bits, 10, fractional bits

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  unit can accept a beat
sigmoid_package  in  width*M  a values, neuron k at bits [width*(k+1)-1:width*k]
sp_package  in  width*M  sigmoid-prime values, same packing
y_package  in  width*M  ideal outputs, same packing
out_valid  out  1  a full bank of deltas is readable
rd_en  in  1  read request
rd_cycle  in  $clog2(C)  beat index to read, 0..C-1
delta_package  out  width*M  deln for rd_cycle; valid 1 cycle after rd_en
rd_release  in  1  single-cycle pulse; consumer has finished with the read bank
sample_done  out  1  single-cycle pulse when the last beat of a sample is written

Behaviour:
- Reset values:
  - Asynchronous reset clears all pipeline valids, wr_cycle, wr_bank, rd_bank, full_cnt and pend_cnt.
  - After reset: in_ready=1, out_valid=0, sample_done=0, delta_package=0.
  - Buffer RAM contents are not cleared.
- Transfer: a beat is accepted when in_valid && in_ready.
- Pipeline, 2 stages:
  - S1 registers diff = sat(a - y). The subtraction is width+1 bits, saturated to [-2^(width-1), 2^(width-1)-1].
  - S2 computes prod = diff * sp as a signed 2*width-bit value, arithmetic-shifts it right by frac_bits (floor), saturates to width bits, and writes it into bank wr_bank at address wr_cycle.
  - Write latency from acceptance to RAM write is 2 cycles.
- wr_cycle: increments on every accepted beat and wraps C-1 -> 0.
- Commit on write of beat C-1:
  - wr_bank toggles, full_cnt increments, and sample_done pulses in the same cycle.
- pend_cnt = full banks + samples whose last beat is accepted but not yet written.
  - Incremented on acceptance of beat C-1; decremented on rd_release.
  - in_ready = (pend_cnt < 2).
  - Mid-sample beats (wr_cycle != 0) are accepted whenever pend_cnt < 2.
- out_valid = (full_cnt > 0). rd_bank selects the oldest full bank.
- Read:
  - rd_en at cycle t with rd_cycle=k gives delta_package = bank[rd_bank][k] at t+1. delta_package holds its value otherwise.
  - rd_en while out_valid=0 is ignored (delta_package holds).
  - rd_cycle >= C is a consumer error; the output is don't-care.
- rd_release:
  - With out_valid=1: decrement full_cnt and pend_cnt, and toggle rd_bank.
  - With out_valid=0: ignored.
- Simultaneous rd_release and commit in the same cycle: full_cnt is unchanged and pend_cnt is net -1+0, i.e. the commit increment was already counted at acceptance.
- Simultaneous rd_release and acceptance of a last beat: pend_cnt is unchanged.
- Reads and writes always target different banks, so there is no read/write collision.
- in_valid low mid-sample: the partial sample is held indefinitely; there is no timeout.
- Reset mid-sample discards the partial sample and any full banks; the unit restarts at beat 0, bank 0.

Test Plan:
1. Basic (n=8, z=8, fi=4 → M=2, C=4):
   - Stimulus: 4 beats, each with a=768 (0.75), y=1024 (1.0), sp=192 (0.1875).
   - Response: sample_done pulses 2 cycles after the 4th acceptance; out_valid=1; reading rd_cycle 0..3 returns 0xFFD0 (-48) in both lanes.
2. Saturation:
   - Stimulus: a=0x7FFF, y=0x8000, sp=0x7FFF.
   - Response: diff saturates to 0x7FFF; delta = 0x7FFF.
   - Stimulus: a=0, y=0, any sp.
   - Response: delta = 0.
3. Back-pressure:
   - Stimulus: stream 3 samples back-to-back, no rd_release.
   - Response: in_ready drops the cycle after the 2nd sample's beat 3 is accepted; the 3rd sample stalls at beat 0. One rd_release raises in_ready next cycle; the 3rd sample lands in bank 0.
4. Simultaneous events:
   - Stimulus: rd_release asserted in the same cycle as a commit with full_cnt=1.
   - Response: out_valid stays 1, rd_bank toggles to the newly committed bank, and the data read matches the 2nd sample.
5. Reset mid-sample:
   - Stimulus: assert reset after 2 beats of a sample with one bank full.
   - Response: immediately out_valid=0 and in_ready=1. After reset, a fresh 4-beat sample commits to bank 0 with correct values.
6. Gapped input:
   - Stimulus: in_valid toggles 1/0 across a sample.
   - Response: wr_cycle advances only on accepted beats; results are identical to scenario 1.
